// File: rtl/pattern_pkg.sv
// Shared types for the serial 10011 pattern scheduler: controller states,
// detector encodings and the overlapping Moore detector transition function.
package pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_t;

  typedef enum logic [2:0] {
    DET_A = 3'b000,
    DET_B = 3'b001,
    DET_C = 3'b010,
    DET_D = 3'b011,
    DET_E = 3'b100,
    DET_F = 3'b101
  } det_state_t;

  // Kept on a raw 3-bit vector so the two unused encodings fall back to A.
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      DET_A:   det_next = b ? DET_B : DET_A;
      DET_B:   det_next = b ? DET_B : DET_C;
      DET_C:   det_next = b ? DET_B : DET_D;
      DET_D:   det_next = b ? DET_E : DET_A;
      DET_E:   det_next = b ? DET_F : DET_C;
      DET_F:   det_next = b ? DET_B : DET_C;
      default: det_next = DET_A;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable tick generator: counts 0..period while enabled and pulses
// o_tick on the cycle the count equals period, wrapping to zero there.
module tick_gen #(
  parameter int DIV_W = 28
) (
  input  logic             main_clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_period,
  input  logic             i_en,
  input  logic             i_clr,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_period);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_scheduler.sv
// Accepts a word over valid/ready and serialises it MSB-first into an
// overlapping 10011 Moore detector at a programmable tick rate.
module serial_pattern_scheduler
  import pattern_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 28,
  parameter int CNT_W  = 8
) (
  input  logic              main_clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div_cfg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              bit_out,
  output logic              bit_strobe,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DATA_W);

  ctrl_state_t       r_state, w_state_nxt;
  logic              r_rdy_en;
  logic [DATA_W-1:0] r_shift;
  logic [DIV_W-1:0]  r_period;
  logic [IDX_W-1:0]  r_idx;
  logic [2:0]        r_det;
  logic [CNT_W-1:0]  r_count;
  logic              w_tick, w_accept, w_last;
  logic [2:0]        w_det_nxt;

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .main_clk (main_clk),
    .rst      (rst),
    .i_period (r_period),
    .i_en     (r_state == ST_SHIFT),
    .i_clr    (w_accept),
    .o_tick   (w_tick)
  );

  assign w_accept    = in_ready && in_valid;
  assign w_last      = (r_idx == IDX_W'(DATA_W - 1));
  assign w_det_nxt   = det_next(r_det, r_shift[DATA_W-1]);
  assign match       = (r_det == DET_F);
  assign match_count = r_count;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    bit_out     = 1'b0;
    bit_strobe  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = r_rdy_en;
        if (r_rdy_en && in_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy       = 1'b1;
        bit_out    = r_shift[DATA_W-1];
        bit_strobe = w_tick;
        if (w_tick && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      r_shift  <= '0;
      r_period <= '0;
      r_idx    <= '0;
      r_det    <= DET_A;
      r_count  <= '0;
    end else if (w_accept) begin
      r_shift  <= in_data;
      r_period <= div_cfg;
      r_idx    <= '0;
      r_det    <= DET_A;
      r_count  <= '0;
    end else if (r_state == ST_SHIFT && w_tick) begin
      r_shift <= {r_shift[DATA_W-2:0], 1'b0};
      r_idx   <= r_idx + IDX_W'(1);
      r_det   <= w_det_nxt;
      if (w_det_nxt == DET_F && r_count != {CNT_W{1'b1}}) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_scheduler.sv
// Directed bench for serial_pattern_scheduler: hand-computed strobe timing,
// match positions and per-word counts, including mid-word reset.
module tb_serial_pattern_scheduler;

  logic        main_clk;
  logic        rst;
  logic [27:0] div_cfg;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        bit_out;
  logic        bit_strobe;
  logic        match;
  logic [7:0]  match_count;
  logic        busy;
  logic        done;

  int  n_tests = 0;
  int  n_fail  = 0;
  time accept_time;

  serial_pattern_scheduler dut (
    .main_clk    (main_clk),
    .rst         (rst),
    .div_cfg     (div_cfg),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .bit_out     (bit_out),
    .bit_strobe  (bit_strobe),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},    32'(in_ready),    32'd0);
    check({tag, " bit_out"},     32'(bit_out),     32'd0);
    check({tag, " bit_strobe"},  32'(bit_strobe),  32'd0);
    check({tag, " match"},       32'(match),       32'd0);
    check({tag, " match_count"}, 32'(match_count), 32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " done"},        32'(done),        32'd0);
  endtask

  // Called at a negedge. Offers one word, then samples every negedge until
  // done (or abort_at strobes seen). exp_mask bit i: match high in the cycle
  // following strobe i+1.
  task automatic run_word(input string tag, input logic [15:0] data, input logic [27:0] cfg,
                          input int exp_cnt, input logic [15:0] exp_mask,
                          input bit hold, input int abort_at);
    int          period, limit, wait_n;
    int          nstrobe, first_strobe, last_strobe, bad_space;
    int          done_cyc, ndone, ready_bad, busy_bad;
    logic [15:0] mask;
    bit          prev_strobe;
    logic [7:0]  cnt_at_done;

    period  = int'(cfg);
    in_data = data;
    div_cfg = cfg;
    in_valid = 1'b1;
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin
      @(negedge main_clk);
      wait_n++;
    end
    check({tag, " accept"}, 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge main_clk);
    accept_time = $time;
    #1;
    if (!hold) in_valid = 1'b0;
    div_cfg = '0;

    nstrobe = 0; first_strobe = 0; last_strobe = 0; bad_space = 0;
    done_cyc = 0; ndone = 0; ready_bad = 0; busy_bad = 0;
    mask = '0; prev_strobe = 1'b0; cnt_at_done = '0;
    limit = 16 * (period + 1) + 4;
    for (int n = 1; n <= limit; n++) begin
      @(negedge main_clk);
      if (prev_strobe && match) mask[nstrobe-1] = 1'b1;
      prev_strobe = bit_strobe;
      if (bit_strobe) begin
        nstrobe++;
        if (nstrobe == 1) first_strobe = n;
        else if (n - last_strobe != period + 1) bad_space++;
        last_strobe = n;
      end
      if (in_ready) ready_bad++;
      if (done) begin
        ndone++;
        done_cyc = n;
        cnt_at_done = match_count;
        if (busy) busy_bad++;
        break;
      end else if (!busy) begin
        busy_bad++;
      end
      if (abort_at > 0 && nstrobe == abort_at) return;
    end

    check({tag, " strobes"},     32'(nstrobe),      32'd16);
    check({tag, " first_strobe"}, 32'(first_strobe), 32'(1 + period));
    check({tag, " spacing"},     32'(bad_space),    32'd0);
    check({tag, " match_mask"},  32'(mask),         32'(exp_mask));
    check({tag, " done_pulses"}, 32'(ndone),        32'd1);
    check({tag, " done_cycle"},  32'(done_cyc),     32'(16 * (period + 1) + 1));
    check({tag, " count"},       32'(cnt_at_done),  32'(exp_cnt));
    check({tag, " busy"},        32'(busy_bad),     32'd0);
    check({tag, " ready_low"},   32'(ready_bad),    32'd0);
    if (!hold) begin
      @(negedge main_clk);
      check({tag, " ready_back"}, 32'(in_ready),    32'd1);
      check({tag, " done_low"},   32'(done),        32'd0);
      check({tag, " count_hold"}, 32'(match_count), 32'(exp_cnt));
    end
  endtask

  initial begin
    time t_prev;
    int  done_seen;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; div_cfg = '0;
    #23;
    check_reset_outputs("por");
    @(negedge main_clk);
    rst = 1'b1;
    @(negedge main_clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    run_word("w9800_p0", 16'h9800, 28'd0, 1, 16'h0010, 1'b0, 0);
    run_word("w9980_p0", 16'h9980, 28'd0, 2, 16'h0110, 1'b0, 0);
    run_word("wFFFF",    16'hFFFF, 28'd0, 0, 16'h0000, 1'b0, 0);
    run_word("w0000",    16'h0000, 28'd0, 0, 16'h0000, 1'b0, 0);
    run_word("w9800_p3", 16'h9800, 28'd3, 1, 16'h0010, 1'b0, 0);

    // in_valid held high across four alternating words
    t_prev = 0;
    for (int w = 0; w < 4; w++) begin
      if (w % 2 == 0) run_word("b2b_9980", 16'h9980, 28'd0, 2, 16'h0110, 1'b1, 0);
      else            run_word("b2b_0000", 16'h0000, 28'd0, 0, 16'h0000, 1'b1, 0);
      if (w > 0) check("b2b_throughput", 32'(accept_time - t_prev), 32'd180);
      t_prev = accept_time;
    end
    in_valid = 1'b0;
    @(negedge main_clk);

    // reset pulse after the 7th strobe of 0x9980
    run_word("abort", 16'h9980, 28'd0, 2, 16'h0110, 1'b0, 7);
    @(negedge main_clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge main_clk);
      if (done) done_seen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge main_clk);
      if (done) done_seen++;
    end
    check("midrst no_done", 32'(done_seen), 32'd0);
    check("midrst ready",   32'(in_ready),  32'd1);
    run_word("after_rst", 16'h9980, 28'd0, 2, 16'h0110, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
